// File: rtl/fft_feeder_pkg.sv
// Shared defaults, state encoding and width helper for the FFT frame feeder.
package fft_feeder_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_FRAME_LEN  = 1024;
    localparam int DEF_FIFO_DEPTH = 2048;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } feeder_state_e;

    // Occupancy counter must represent the completely full value, hence +1.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fft_feeder_ram.sv
// Simple dual-port sample store with registered read; old data is returned
// when reading an address that is being written in the same cycle.
module fft_feeder_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers a complex sample stream and releases it to the FFT sink in whole,
// bubble-free frames. Optional frame counter: FFT_FEEDER_FRAME_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a full frame in the buffer, src_valid low
// SEND  | streaming FRAME_LEN beats, idx_q is the beat index
module fft_frame_feeder
    import fft_feeder_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    input  logic              cfg_inverse,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop,
    output logic [DATA_W-1:0] src_real,
    output logic [DATA_W-1:0] src_imag,
    output logic [1:0]        src_error,
`ifdef FFT_FEEDER_FRAME_CNT_EN
    output logic [15:0]       frame_count,
`endif
    output logic              src_inverse
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = count_width(FIFO_DEPTH);
    localparam int IW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_LEN);
    localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_LEN - 1);

    feeder_state_e       state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_raddr;
    logic [CW-1:0]       count_q, count_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [2*DATA_W-1:0] out_q, out_d, ram_rdata;
    logic                inv_q, inv_d;
    logic                wr_en, rd_xfer, eop_xfer, load_out;

    assign in_ready  = (count_q < FULL_CNT);
    assign wr_en     = in_valid && in_ready;
    assign rd_xfer   = src_valid && src_ready;
    assign eop_xfer  = rd_xfer && src_eop;
    assign src_real  = out_q[2*DATA_W-1:DATA_W];
    assign src_imag  = out_q[DATA_W-1:0];
    assign src_error = 2'b00;
    assign src_inverse = inv_q;

    fft_feeder_ram #(
        .WIDTH  (2*DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data ({in_real, in_imag}),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            out_q    <= '0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            out_q    <= out_d;
            inv_q    <= inv_d;
        end
    end

    // A new frame may follow the eop beat directly only if it is fully buffered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q >= FRAME_CNT) state_d = SEND;
            SEND:    if (eop_xfer && (count_q <= FRAME_CNT)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        src_valid = (state_q == SEND);
        src_sop   = src_valid && (idx_q == '0);
        src_eop   = src_valid && (idx_q == LAST_IDX);
    end

    // rd_ptr is the sample shown on the output register; while sending, the
    // RAM is kept one sample ahead so a transfer can reload out_q at once.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(wr_en);
        rd_ptr_d  = rd_ptr_q + AW'(rd_xfer);
        count_d   = count_q + CW'(wr_en) - CW'(rd_xfer);
        idx_d     = idx_q;
        if (rd_xfer) begin
            idx_d = src_eop ? '0 : idx_q + IW'(1);
        end
        ram_raddr = rd_ptr_d + ((state_d == SEND) ? AW'(1) : AW'(0));
        load_out  = (state_d == SEND) && ((state_q == IDLE) || rd_xfer);
        out_d     = load_out ? ram_rdata : out_q;
        inv_d     = inv_q;
        if ((state_d == SEND) && ((state_q == IDLE) || eop_xfer)) begin
            inv_d = cfg_inverse;
        end
    end

`ifdef FFT_FEEDER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(eop_xfer);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: scoreboard of accepted samples,
// per-beat sop/eop/inverse checks and stall-hold checks.
module tb_fft_frame_feeder;

    localparam int FL = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_real, in_imag;
    logic        cfg_inverse;
    logic        src_valid, src_ready, src_sop, src_eop, src_inverse;
    logic [15:0] src_real, src_imag;
    logic [1:0]  src_error;
`ifdef FFT_FEEDER_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    fft_frame_feeder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .cfg_inverse (cfg_inverse),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_sop     (src_sop),
        .src_eop     (src_eop),
        .src_real    (src_real),
        .src_imag    (src_imag),
        .src_error   (src_error),
`ifdef FFT_FEEDER_FRAME_CNT_EN
        .frame_count (frame_count),
`endif
        .src_inverse (src_inverse)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    int          gaps[$];
    int          beat_idx = 0;
    int          sop_cnt = 0, eop_cnt = 0, eops_since_rst = 0;
    int          cyc = 0, last_eop_cyc = 0;
    logic        exp_inv = 1'b0, exp_inv_next = 1'b0;
    logic        stall_prev = 1'b0;
    logic [35:0] prev_out = '0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs at every falling edge, where inputs and outputs are stable.
    task automatic mon_step();
        logic [31:0] eb;
        logic [35:0] cur;
        cur = {src_valid, src_sop, src_eop, src_inverse, src_real, src_imag};
        if (reset) begin
            exp_q.delete();
            beat_idx = 0;
            stall_prev = 1'b0;
            eops_since_rst = 0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back({in_real, in_imag});
            if (stall_prev) check_val("stall_hold", cur, prev_out);
            if (src_valid && src_ready) begin
                if (beat_idx == 0) begin
                    exp_inv = exp_inv_next;
                    sop_cnt++;
                    gaps.push_back(cyc - last_eop_cyc - 1);
                end
                if (exp_q.size() == 0) begin
                    check_val("beat_extra", 1, 0);
                end else begin
                    eb = exp_q.pop_front();
                    check_val("beat_data", {src_real, src_imag}, eb);
                end
                check_val("beat_sop", src_sop, beat_idx == 0);
                check_val("beat_eop", src_eop, beat_idx == FL - 1);
                check_val("beat_inv", src_inverse, exp_inv);
                if (beat_idx == FL - 1) begin
                    eop_cnt++;
                    eops_since_rst++;
                    last_eop_cyc = cyc;
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
            stall_prev = src_valid && !src_ready;
            prev_out = cur;
        end
        cyc++;
    endtask

    task automatic stream(input int n, input int base, input bit rnd);
        int k = 0;
        while (k < n) begin
            in_valid = 1'b1;
            in_real  = 16'(base + k);
            in_imag  = 16'(-(base + k));
            if (rnd) src_ready = 1'($urandom_range(0, 1));
            if (in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc, input bit rnd);
        int n = 0;
        while ((exp_q.size() != 0 || src_valid) && n < max_cyc) begin
            if (rnd) src_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check_val("drain_done", n < max_cyc, 1);
        src_ready = 1'b1;
    endtask

    task automatic wait_beat(input int target);
        int n = 0;
        while (beat_idx < target && n < 4000) begin
            tick();
            n++;
        end
        check_val("wait_beat", beat_idx >= target, 1);
    endtask

    initial begin
        int sop0, eop0, g0, acc;
        reset = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0;
        src_ready = 1'b0; cfg_inverse = 1'b0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none
        tick(); tick();
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_outs", {src_valid, src_sop, src_eop, src_inverse, src_error}, 0);
        check_val("rst_data", {src_real, src_imag}, 0);
        reset = 1'b0;
        src_ready = 1'b1;
        tick();

        // one frame, first-beat latency
        stream(FL, 0, 0);
        check_val("lat_cyc1_valid", src_valid, 0);
        tick();
        check_val("lat_cyc2_valid", src_valid, 1);
        check_val("first_sop", src_sop, 1);
        check_val("first_real", src_real, 0);
        drain(3000, 0);

        // three back-to-back frames
        sop0 = sop_cnt; eop0 = eop_cnt; g0 = gaps.size();
        stream(3 * FL, 2000, 0);
        drain(5000, 0);
        check_val("b2b_sops", sop_cnt - sop0, 3);
        check_val("b2b_eops", eop_cnt - eop0, 3);
        check_val("b2b_gap1", gaps[g0 + 1], 0);
        check_val("b2b_gap2", gaps[g0 + 2], 0);

        // random backpressure
        sop0 = sop_cnt; eop0 = eop_cnt;
        stream(2 * FL, 6000, 1);
        drain(8000, 1);
        check_val("rnd_sops", sop_cnt - sop0, 2);
        check_val("rnd_eops", eop_cnt - eop0, 2);

        // fill to capacity with the sink stalled
        sop0 = sop_cnt; eop0 = eop_cnt;
        src_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 2100; i++) begin
            in_valid = 1'b1;
            in_real  = 16'(9000 + acc);
            in_imag  = 16'(-(9000 + acc));
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check_val("full_accepted", acc, 2048);
        check_val("full_in_ready", in_ready, 0);
        check_val("full_valid", src_valid, 1);
        src_ready = 1'b1;
        #1;
        check_val("pre_release_ready", in_ready, 0);
        tick();
        check_val("release_ready", in_ready, 1);
        drain(5000, 0);
        check_val("full_sops", sop_cnt - sop0, 2);
        check_val("full_eops", eop_cnt - eop0, 2);

        // inverse flag latched per frame
        cfg_inverse = 1'b1; exp_inv_next = 1'b1;
        stream(FL, 12000, 0);
        wait_beat(500);
        cfg_inverse = 1'b0; exp_inv_next = 1'b0;
        tick();
        check_val("inv_hold", src_inverse, 1);
        stream(FL, 13024, 0);
        drain(4000, 0);
        check_val("inv_after", src_inverse, 0);

        // reset mid-frame, then a fresh frame
        stream(FL, 0, 0);
        wait_beat(500);
        check_val("pre_rst_valid", src_valid, 1);
        reset = 1'b1;
        tick();
        check_val("midrst_valid", src_valid, 0);
        check_val("midrst_in_ready", in_ready, 1);
        check_val("midrst_sop_eop", {src_sop, src_eop}, 0);
        reset = 1'b0;
        sop0 = sop_cnt;
        stream(FL, 0, 0);
        check_val("post_rst_lat1", src_valid, 0);
        tick();
        check_val("post_rst_valid", src_valid, 1);
        check_val("post_rst_sop", src_sop, 1);
        check_val("post_rst_real", src_real, 0);
        drain(3000, 0);
        check_val("post_rst_sops", sop_cnt - sop0, 1);
`ifdef FFT_FEEDER_FRAME_CNT_EN
        check_val("frame_count", frame_count, 16'(eops_since_rst));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_feeder.md
# fft_frame_feeder

Frames a continuous complex sample stream into 1024-point bursts and drives the sink port of the 16x1024 burst FFT core. Buffers at least one full frame before releasing it, so every frame reaches the FFT as a contiguous run of valid beats with correct sop/eop marking. The FFT's sink_ready provides backpressure. Sits between the front-end sample source and the FFT sink; it is the transmitter for the FFT's receive side.

## Interface
- DATA_W, 16, width of each real/imag component
- FRAME_LEN, 1024, samples per FFT frame (power of two)
- FIFO_DEPTH, 2048, buffer depth in samples (power of two, ≥ 2·FRAME_LEN)

- clk  in  1  single clock for the whole block
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_real  in  DATA_W  input real, two's complement
- in_imag  in  DATA_W  input imag, two's complement
- cfg_inverse  in  1  transform direction for the next frame
- src_valid  out  1  to FFT sink_valid
- src_ready  in  1  from FFT sink_ready
- src_sop  out  1  to FFT sink_sop
- src_eop  out  1  to FFT sink_eop
- src_real  out  DATA_W  to FFT sink_real
- src_imag  out  DATA_W  to FFT sink_imag
- src_error  out  2  to FFT sink_error; constant 2'b00
- src_inverse  out  1  to FFT inverse; stable for the whole frame

## Operation
- Input transfer: in_valid & in_ready in the same cycle. Output transfer: src_valid & src_ready in the same cycle (ready latency 0).
- FIFO: occupancy `count`, width clog2(FIFO_DEPTH)+1. Write pointer and read pointer wrap modulo FIFO_DEPTH.
- in_ready = (count < FIFO_DEPTH), computed from registered count. No write when full, so overflow cannot occur.
- State machine has two states:
  - IDLE: src_valid=0. Go to SEND when count ≥ FRAME_LEN. On entry to SEND, latch cfg_inverse into src_inverse.
  - SEND: emits FRAME_LEN beats, indexed by sample counter `idx` (0..FRAME_LEN-1).
    - src_sop = (idx==0). src_eop = (idx==FRAME_LEN-1).
    - idx advances only on an output transfer.
    - On the eop transfer: return to IDLE, or stay in SEND with idx=0 if a further full frame is already buffered.
- src_valid stays high throughout SEND; a frame is never interrupted by bubbles. While src_valid=1 and src_ready=0, all src_* outputs hold.
- Simultaneous input write and output read: count is unchanged.
- Reset mid-frame: FIFO flushed, idx=0, IDLE. The partial frame is discarded with no eop emitted; the FFT is reset alongside.
- Reset values: in_ready=1, src_valid=0, src_sop=0, src_eop=0, src_real=0, src_imag=0, src_error=0, src_inverse=0.

## Timing
- RAM read latency is 1 cycle. The output register is first-word-fall-through, fed by one prefetch stage.
- First beat: src_valid rises 2 cycles after the cycle accepting the FRAME_LEN-th sample of a frame.
- With src_ready held high, FRAME_LEN consecutive beats are emitted, one per cycle.
- Back-to-back frames: with the next frame already buffered, its sop beat directly follows the previous eop beat (0 gap cycles).
- in_ready deasserts the cycle after count reaches FIFO_DEPTH. It reasserts the cycle after the first output transfer.

## Configuration
- FFT_FEEDER_FRAME_CNT_EN defined:
  - adds output port frame_count [15:0], reset 0.
  - frame_count increments on every eop transfer and wraps at 0xFFFF→0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package fft_feeder_pkg holds:
  - DATA_W and FRAME_LEN defaults
  - the state enum (IDLE, SEND)
  - a function returning the counter width
- Sub-module fft_feeder_ram: simple dual-port RAM, 2·DATA_W wide, FIFO_DEPTH deep, registered read. It holds only storage; pointers and count stay in the top level.

## Test plan
- Stream 1024 samples (real=i, imag=-i) with src_ready=1 → 1024 beats, sop on real=0, eop on real=1023, src_valid high 2 cycles after the last input.
- Stream 3072 samples continuously with src_ready=1 → three frames, no gap between eop and the next sop, data in order.
- Toggle src_ready on a 50% random pattern mid-frame → no data loss or duplication; outputs stable while stalled; exactly one sop and one eop per frame.
- Hold src_ready=0 and feed 2100 samples → in_ready drops at count 2048, only 2048 samples accepted; after release, two correct frames are emitted.
- Set cfg_inverse=1, then change it to 0 mid-frame → src_inverse stays 1 until the eop transfer and takes the new value at the next sop.
- Assert reset at idx=500 → next cycle src_valid=0, in_ready=1, count=0; a fresh 1024-sample frame then starts again at sop with real=0.
